// File: rtl/bcd_to_binary.sv
// Sequential four-digit BCD to binary converter, one Horner step per cycle.
// Optional invalid-digit flag enabled by defining BCD_TO_BINARY_DIGIT_CHECK_EN.
module bcd_to_binary #(
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       thousands,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] value,
    output logic             overflow
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    ,output logic            digit_err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [13:0] MAX_VAL = 14'((32'd1 << OUT_W) - 32'd1);

    logic [1:0]  state;
    logic [13:0] acc;
    logic [13:0] acc_next;
    logic [1:0]  idx;
    logic [15:0] digits;
    logic [3:0]  cur_digit;

    // digits packs thousands..ones from MSB to LSB, so idx 3 selects thousands
    always_comb begin
        cur_digit = digits[{idx, 2'b00} +: 4];
        acc_next  = (acc << 3) + (acc << 1) + {10'd0, cur_digit};
    end

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic bad_digit;

    always_comb begin
        bad_digit = (digits[15:12] > 4'd9) || (digits[11:8] > 4'd9) ||
                    (digits[7:4]   > 4'd9) || (digits[3:0]  > 4'd9);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            idx      <= '0;
            digits   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            value    <= '0;
            overflow <= 1'b0;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
            digit_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        digits <= {thousands, hundreds, tens, ones};
                        acc    <= '0;
                        idx    <= 2'd3;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    idx <= idx - 2'd1;
                    if (idx == 2'd0) begin
                        state <= OUT;
                    end
                end
                OUT: begin
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
                    if (bad_digit) begin
                        digit_err <= 1'b1;
                        value     <= '0;
                        overflow  <= 1'b0;
                    end else begin
                        digit_err <= 1'b0;
`else
                    begin
`endif
                        // Saturate rather than truncate when the result does not fit
                        if (acc > MAX_VAL) begin
                            value    <= '1;
                            overflow <= 1'b1;
                        end else begin
                            value    <= acc[OUT_W-1:0];
                            overflow <= 1'b0;
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary, with a 10-bit and a 14-bit instance.
// Honours BCD_TO_BINARY_DIGIT_CHECK_EN when the design is built with it.
module tb_bcd_to_binary;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic        busy, done, overflow;
    logic [9:0]  value;
    logic        busy14, done14, overflow14;
    logic [13:0] value14;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic        digit_err, digit_err14;
`endif

    int checks = 0;
    int errors = 0;

    bcd_to_binary #(.OUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .busy(busy), .done(done), .value(value), .overflow(overflow)
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        , .digit_err(digit_err)
`endif
    );

    bcd_to_binary #(.OUT_W(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .busy(busy14), .done(done14), .value(value14), .overflow(overflow14)
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        , .digit_err(digit_err14)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present digits with a one-cycle start; returns just after the accepting edge
    task automatic applyStimulus(input logic [3:0] th, input logic [3:0] hu,
                                 input logic [3:0] te, input logic [3:0] on);
        thousands = th;
        hundreds  = hu;
        tens      = te;
        ones      = on;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 5);
        checkOutput({tag, "_busycycles"}, busy_cnt, 5);
        checkOutput({tag, "_busy14_at_done"}, int'(busy14), 0);
        checkOutput({tag, "_done14"}, int'(done14), 1);
    endtask

    task automatic checkResult(input string tag, input int v10, input int o10,
                               input int v14, input int o14, input int err);
        checkOutput({tag, "_value"}, int'(value), v10);
        checkOutput({tag, "_ovf"}, int'(overflow), o10);
        checkOutput({tag, "_value14"}, int'(value14), v14);
        checkOutput({tag, "_ovf14"}, int'(overflow14), o14);
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        checkOutput({tag, "_digit_err"}, int'(digit_err), err);
        checkOutput({tag, "_digit_err14"}, int'(digit_err14), err);
`else
        checkOutput({tag, "_err_unused"}, err, 0);
`endif
    endtask

    initial begin
        int extra;
        rst_n     = 1'b0;
        start     = 1'b0;
        thousands = 4'd0;
        hundreds  = 4'd0;
        tens      = 4'd0;
        ones      = 4'd0;
        repeat (3) step();

        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_value", int'(value), 0);
        checkOutput("rst_ovf", int'(overflow), 0);
        checkOutput("rst_value14", int'(value14), 0);
        rst_n = 1'b1;
        step();

        $display("[TB] single conversion 0003");
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd3);
        checkOutput("c3_busy_after_start", int'(busy), 1);
        waitDone("c3");
        checkResult("c3", 3, 0, 3, 0, 0);
        step();
        checkOutput("c3_done_one_cycle", int'(done), 0);
        checkOutput("c3_value_held", int'(value), 3);

        $display("[TB] back-to-back 0333 then 1011");
        applyStimulus(4'd0, 4'd3, 4'd3, 4'd3);
        waitDone("c333");
        checkResult("c333", 333, 0, 333, 0, 0);
        applyStimulus(4'd1, 4'd0, 4'd1, 4'd1);
        checkOutput("c1011_done_cleared", int'(done), 0);
        checkOutput("c1011_busy", int'(busy), 1);
        waitDone("c1011");
        checkResult("c1011", 1011, 0, 1011, 0, 0);

        $display("[TB] saturation 1999 and 9999");
        applyStimulus(4'd1, 4'd9, 4'd9, 4'd9);
        waitDone("c1999");
        checkResult("c1999", 1023, 1, 1999, 0, 0);
        applyStimulus(4'd9, 4'd9, 4'd9, 4'd9);
        waitDone("c9999");
        checkResult("c9999", 1023, 1, 9999, 0, 0);

        $display("[TB] inputs changed during conversion");
        applyStimulus(4'd0, 4'd1, 4'd2, 4'd3);
        thousands = 4'd9;
        hundreds  = 4'd9;
        tens      = 4'd9;
        ones      = 4'd9;
        start     = 1'b1;
        step();
        step();
        start = 1'b0;
        extra = 0;
        while (!done && extra < 20) begin
            step();
            extra++;
        end
        checkOutput("chg_latency", extra + 2, 5);
        checkResult("chg", 123, 0, 123, 0, 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) extra++;
        end
        checkOutput("chg_no_extra_done", extra, 0);
        checkOutput("chg_idle", int'(busy), 0);

        $display("[TB] reset during conversion");
        applyStimulus(4'd0, 4'd5, 4'd5, 4'd5);
        step();
        step();
        rst_n = 1'b0;
        step();
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_value", int'(value), 0);
        checkOutput("abort_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || done14) extra++;
        end
        checkOutput("abort_no_done", extra, 0);
        applyStimulus(4'd1, 4'd0, 4'd0, 4'd0);
        waitDone("c1000");
        checkResult("c1000", 1000, 0, 1000, 0, 0);

        $display("[TB] out-of-range tens digit");
        applyStimulus(4'd0, 4'd0, 4'hA, 4'd0);
        waitDone("cA0");
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
        checkResult("cA0", 0, 0, 0, 0, 1);
`else
        checkResult("cA0", 100, 0, 100, 0, 0);
`endif
        applyStimulus(4'd0, 4'd0, 4'd4, 4'd2);
        waitDone("c42");
        checkResult("c42", 42, 0, 42, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
